// File: rtl/dpram_pkg.sv
// Shared definitions for the byte-enabled synchronous dual-port RAM:
// controller states, byte-lane count derivation and lane parity.
package dpram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dpram_state_e;

  function automatic int be_w(input int data_size);
    return data_size / 8;
  endfunction

  // Even parity: the stored bit makes the total number of ones in the lane even.
  function automatic logic lane_par(input logic [7:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/dpram_sync_be_if.sv
// Write/read port bundle for dpram_sync_be. The parity error-injection input
// and the parity error output exist only when DPRAM_SYNC_BE_PARITY_EN is defined.
interface dpram_sync_be_if #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 16
) ();
  import dpram_pkg::*;

  localparam int BE_W = be_w(DATA_SIZE);

  logic                 wr_en;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [DATA_SIZE-1:0] wr_data;
  logic [BE_W-1:0]      wr_be;
  logic                 rd_en;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 rd_valid;
  logic                 init_busy;
`ifdef DPRAM_SYNC_BE_PARITY_EN
  logic                 wr_par_flip;
  logic                 parity_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, wr_par_flip,
    input  rd_data, rd_valid, init_busy, parity_err
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, wr_par_flip,
    output rd_data, rd_valid, init_busy, parity_err
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy
  );
`endif

endinterface

// File: rtl/dpram_rd_pipe.sv
// Valid/data delay line of LATENCY stages. Data registers only load on valid,
// so the last stage holds the most recent result between reads.
module dpram_rd_pipe #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic [LATENCY-1:0]            vld_q;
  logic [LATENCY-1:0][WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) data_q[0] <= data_i;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) data_q[k] <= data_q[k-1];
      end
    end
  end

  assign vld_o  = vld_q[LATENCY-1];
  assign data_o = data_q[LATENCY-1];

endmodule

// File: rtl/dpram_sync_be.sv
// Synchronous dual-port RAM with byte-lane writes, 1/2-cycle read latency,
// selectable collision mode and a post-reset clearing sequencer.
// Optional per-lane parity: define DPRAM_SYNC_BE_PARITY_EN.
module dpram_sync_be
  import dpram_pkg::*;
#(
  parameter int ADDR_SIZE    = 4,
  parameter int DATA_SIZE    = 16,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1
) (
  input  logic           clk,
  input  logic           reset,
  dpram_sync_be_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam int BE_W  = be_w(DATA_SIZE);
`ifdef DPRAM_SYNC_BE_PARITY_EN
  localparam int PIPE_W = DATA_SIZE + 1;
`else
  localparam int PIPE_W = DATA_SIZE;
`endif

  dpram_state_e         state_q;
  logic [ADDR_SIZE-1:0] init_cnt_q;
  logic                 init_busy_q;
  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic                 wr_fire, rd_fire, collide;
  logic [DATA_SIZE-1:0] rd_word_d;
  logic [PIPE_W-1:0]    pipe_in, pipe_out;
  logic                 pipe_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (&init_cnt_q) begin
            state_q     <= ST_RUN;
            init_busy_q <= 1'b0;
          end else begin
            init_cnt_q <= init_cnt_q + ADDR_SIZE'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign wr_fire = (state_q == ST_RUN) && bus.wr_en;
  assign rd_fire = (state_q == ST_RUN) && bus.rd_en;
  assign collide = wr_fire && (bus.wr_addr == bus.rd_addr) && (WRITE_FIRST != 0);

  // Storage has no reset; the sequencer clears it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < BE_W; i++)
        if (bus.wr_be[i]) mem_q[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_word_d = mem_q[bus.rd_addr];
    if (collide)
      for (int i = 0; i < BE_W; i++)
        if (bus.wr_be[i]) rd_word_d[8*i +: 8] = bus.wr_data[8*i +: 8];
  end

`ifdef DPRAM_SYNC_BE_PARITY_EN
  logic [BE_W-1:0] par_q [DEPTH];
  logic [BE_W-1:0] rd_par_d;
  logic            rd_err_d;

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      par_q[init_cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < BE_W; i++)
        if (bus.wr_be[i])
          par_q[bus.wr_addr][i] <= lane_par(bus.wr_data[8*i +: 8]) ^ bus.wr_par_flip;
    end
  end

  // Parity is checked on exactly the word returned, merged lanes included.
  always_comb begin
    rd_par_d = par_q[bus.rd_addr];
    if (collide)
      for (int i = 0; i < BE_W; i++)
        if (bus.wr_be[i]) rd_par_d[i] = lane_par(bus.wr_data[8*i +: 8]) ^ bus.wr_par_flip;
    rd_err_d = 1'b0;
    for (int i = 0; i < BE_W; i++)
      rd_err_d = rd_err_d | (lane_par(rd_word_d[8*i +: 8]) ^ rd_par_d[i]);
  end

  assign pipe_in        = {rd_err_d, rd_word_d};
  assign bus.parity_err = pipe_vld & pipe_out[DATA_SIZE];
`else
  assign pipe_in = rd_word_d;
`endif

  dpram_rd_pipe #(
    .WIDTH   (PIPE_W),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk    (clk),
    .reset  (reset),
    .vld_i  (rd_fire),
    .data_i (pipe_in),
    .vld_o  (pipe_vld),
    .data_o (pipe_out)
  );

  assign bus.rd_valid  = pipe_vld;
  assign bus.rd_data   = pipe_out[DATA_SIZE-1:0];
  assign bus.init_busy = init_busy_q;

endmodule

// File: doc/dpram_sync_be.md
Name: dpram_sync_be

Overview:
- Parametrised synchronous dual-port RAM: one write port, one read port, one clock.
- Successor to the asynchronous dual-port RAM. Adds:
  - byte-lane write enables
  - configurable read latency
  - defined read/write collision behaviour
  - a self-clearing init sequencer after reset
- Used as the storage primitive under FIFOs and buffers in the datapath.

Parameters:
- ADDR_SIZE, 4, address width; DEPTH = 2**ADDR_SIZE entries.
- DATA_SIZE, 16, word width; must be a multiple of 8; BE_W = DATA_SIZE/8.
- READ_LATENCY, 1, cycles from accepted read to rd_valid; legal values 1 or 2.
- WRITE_FIRST, 1, collision mode: 1 = new data returned, 0 = old data returned.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- wr_en  input  1  write request
- wr_addr  input  ADDR_SIZE  write address
- wr_data  input  DATA_SIZE  write data
- wr_be  input  BE_W  byte-lane enables; bit i covers wr_data[8i+7:8i]
- rd_en  input  1  read request
- rd_addr  input  ADDR_SIZE  read address
- rd_data  output  DATA_SIZE  read data; holds its value between reads
- rd_valid  output  1  one-cycle pulse qualifying rd_data
- init_busy  output  1  high while the init sequencer is clearing memory

Behaviour:
- Reset assertion (asynchronous):
  - rd_data=0, rd_valid=0, init_busy=1.
  - Read pipeline flushed; init counter=0; FSM=INIT.
  - Memory array is not reset directly.
- FSM INIT:
  - Writes 0 to address init_cnt every cycle; init_cnt increments.
  - After the write to DEPTH-1, moves to RUN.
  - init_busy is high for exactly DEPTH cycles after reset release.
  - wr_en/rd_en are ignored (dropped, not queued) during INIT.
- FSM RUN: stays in RUN until reset.
- Write (RUN, wr_en=1): at the clock edge, each lane with wr_be[i]=1 is updated. wr_be=0 performs no write.
- Read (RUN, rd_en=1):
  - rd_addr is sampled at the edge.
  - Data appears on rd_data with rd_valid=1 exactly READ_LATENCY cycles later.
  - Back-to-back reads sustain one result per cycle.
- Collision (rd_en & wr_en, rd_addr==wr_addr, same edge):
  - WRITE_FIRST=1: returned word uses wr_data on enabled lanes and stored data on the others.
  - WRITE_FIRST=0: returns the pre-write stored word.
- Read of an address written on the previous edge always returns the new data; no extra bypass is needed beyond the collision case.
- Addresses cover the full 0..DEPTH-1 range. No out-of-range case; the init counter wraps to 0 only via reset.
- Reset mid-operation: in-flight reads are discarded (no rd_valid), and INIT restarts from address 0.

Optional Feature:
- Macro: DPRAM_SYNC_BE_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte lane; INIT writes parity 0.
  - Extra input wr_par_flip (1 bit) inverts the stored parity of enabled lanes on that write, for error injection.
  - Extra output parity_err (1 bit) pulses together with rd_valid when any lane's recomputed parity mismatches; reset value 0.
  - On a WRITE_FIRST collision, parity is checked on the merged word.
- When undefined: no parity storage and no extra ports; the block is otherwise identical.

Decomposition:
- Shared package dpram_pkg holds:
  - FSM state encoding (ST_INIT, ST_RUN)
  - BE_W derivation function
  - lane-parity function
- Natural sub-module: dpram_rd_pipe, a READ_LATENCY-deep valid/data delay line with asynchronous active-low flush. Instantiated once.

Test Plan:
- Init: release reset, then wr_en=1 to addr 3 during INIT → write dropped. init_busy high exactly 16 cycles. After INIT, reads of addr 0..15 all return 0x0000.
- Byte lanes: write 0xABCD, be=11 to addr 5, then 0x1234, be=01 to addr 5 → read addr 5 gives 0xAB34; rd_valid arrives READ_LATENCY cycles after rd_en.
- Collision: addr 7 holds 0x1111; same-cycle write 0x2222, be=10 and read of addr 7 → WRITE_FIRST=1 returns 0x2211, WRITE_FIRST=0 returns 0x1111; a later read returns 0x2211 in both modes.
- Streaming: 16 back-to-back reads of addrs 0..15 with random-filled data (READ_LATENCY=2) → 16 consecutive rd_valid pulses in order, matching the scoreboard.
- Reset mid-read: assert reset one cycle after rd_en → no rd_valid, rd_data=0, init_busy re-asserts for 16 cycles.
- Parity (macro defined): write addr 2 with wr_par_flip=1, be=01, then read addr 2 → parity_err=1 coincident with rd_valid. A read of addr 3 → parity_err=0.
